// File: rtl/pciecfg_pkg.sv
// Shared types for the PCIe configuration-space access engine.
package pciecfg_pkg;

    localparam int unsigned DWADDR_W = 10;
    localparam int unsigned TAG_W    = 8;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned BE_W     = 4;
    localparam int unsigned STATUS_W = 2;
    localparam int unsigned WAIT_W   = 8;
    localparam int unsigned STAT_W   = 16;

    // Request FIFO entry
    typedef struct packed {
        logic                is_write;
        logic [TAG_W-1:0]    tag;
        logic [DWADDR_W-1:0] dwaddr;
        logic [BE_W-1:0]     byte_en;
        logic [DATA_W-1:0]   data;
    } fifo_pciecfg_t;

    // Response FIFO entry
    typedef struct packed {
        logic                is_write;
        logic [TAG_W-1:0]    tag;
        logic [STATUS_W-1:0] status;
        logic [DATA_W-1:0]   data;
    } fifo_pciecfg_resp_t;

    localparam logic [STATUS_W-1:0] STATUS_OK      = 2'b00;
    localparam logic [STATUS_W-1:0] STATUS_TIMEOUT = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ACCESS,
        ST_RESP
    } state_t;

endpackage

// File: rtl/pciecfg_access.sv
// Pops config requests from a FIFO, runs them against the PCIe core's
// cfg_mgmt port one at a time, and pushes a tagged response with status.
module pciecfg_access
    import pciecfg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    pcie_clk,
    input  logic                    pcie_rst,
    input  logic                    fifo_pciecfg_o_empty,
    output logic                    fifo_pciecfg_o_rd_en,
    input  fifo_pciecfg_t           fifo_pciecfg_o_dout,
    output logic [DWADDR_W-1:0]     cfg_mgmt_dwaddr,
    output logic [DATA_W-1:0]       cfg_mgmt_di,
    output logic [BE_W-1:0]         cfg_mgmt_byte_en,
    output logic                    cfg_mgmt_rd_en,
    output logic                    cfg_mgmt_wr_en,
    output logic                    cfg_mgmt_wr_readonly,
    input  logic                    cfg_mgmt_rd_wr_done,
    input  logic [DATA_W-1:0]       cfg_mgmt_do,
    output logic                    fifo_pciecfg_resp_wr_en,
    output fifo_pciecfg_resp_t      fifo_pciecfg_resp_din,
    input  logic                    fifo_pciecfg_resp_full,
    output logic [STAT_W-1:0]       stat_timeout_cnt
);

    // Last wait-count value on which the strobe is still held
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    state_t             state;
    logic               req_is_write;
    logic [TAG_W-1:0]   req_tag;
    logic [WAIT_W-1:0]  wait_cnt;

    assign cfg_mgmt_wr_readonly = 1'b0;

    // Access sequencer: pop, fetch, strobe the core, then report
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            state                   <= ST_IDLE;
            fifo_pciecfg_o_rd_en    <= 1'b0;
            cfg_mgmt_rd_en          <= 1'b0;
            cfg_mgmt_wr_en          <= 1'b0;
            cfg_mgmt_dwaddr         <= '0;
            cfg_mgmt_di             <= '0;
            cfg_mgmt_byte_en        <= '0;
            fifo_pciecfg_resp_wr_en <= 1'b0;
            fifo_pciecfg_resp_din   <= '0;
            stat_timeout_cnt        <= '0;
            wait_cnt                <= '0;
            req_is_write            <= 1'b0;
            req_tag                 <= '0;
        end else begin
            fifo_pciecfg_o_rd_en    <= 1'b0;
            fifo_pciecfg_resp_wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // The pop strobe occupies one IDLE cycle; data follows a cycle later
                    if (fifo_pciecfg_o_rd_en) begin
                        state <= ST_FETCH;
                    end else if (!fifo_pciecfg_o_empty && !fifo_pciecfg_resp_full) begin
                        fifo_pciecfg_o_rd_en <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    req_is_write     <= fifo_pciecfg_o_dout.is_write;
                    req_tag          <= fifo_pciecfg_o_dout.tag;
                    cfg_mgmt_dwaddr  <= fifo_pciecfg_o_dout.dwaddr;
                    cfg_mgmt_di      <= fifo_pciecfg_o_dout.is_write ? fifo_pciecfg_o_dout.data : '0;
                    cfg_mgmt_byte_en <= fifo_pciecfg_o_dout.is_write ? fifo_pciecfg_o_dout.byte_en : '0;
                    cfg_mgmt_wr_en   <= fifo_pciecfg_o_dout.is_write;
                    cfg_mgmt_rd_en   <= !fifo_pciecfg_o_dout.is_write;
                    wait_cnt         <= '0;
                    state            <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (cfg_mgmt_rd_wr_done) begin
                        cfg_mgmt_rd_en                 <= 1'b0;
                        cfg_mgmt_wr_en                 <= 1'b0;
                        fifo_pciecfg_resp_din.is_write <= req_is_write;
                        fifo_pciecfg_resp_din.tag      <= req_tag;
                        fifo_pciecfg_resp_din.status   <= STATUS_OK;
                        fifo_pciecfg_resp_din.data     <= req_is_write ? '0 : cfg_mgmt_do;
                        fifo_pciecfg_resp_wr_en        <= !fifo_pciecfg_resp_full;
                        state                          <= ST_RESP;
                    end else begin
                        if (wait_cnt != '1) begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                        if (wait_cnt == WAIT_LAST) begin
                            cfg_mgmt_rd_en                 <= 1'b0;
                            cfg_mgmt_wr_en                 <= 1'b0;
                            fifo_pciecfg_resp_din.is_write <= req_is_write;
                            fifo_pciecfg_resp_din.tag      <= req_tag;
                            fifo_pciecfg_resp_din.status   <= STATUS_TIMEOUT;
                            fifo_pciecfg_resp_din.data     <= '0;
                            fifo_pciecfg_resp_wr_en        <= !fifo_pciecfg_resp_full;
                            if (stat_timeout_cnt != '1) begin
                                stat_timeout_cnt <= stat_timeout_cnt + STAT_W'(1);
                            end
                            state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    // A push in flight completes the access; otherwise retry when space frees
                    if (fifo_pciecfg_resp_wr_en) begin
                        state <= ST_IDLE;
                    end else if (!fifo_pciecfg_resp_full) begin
                        fifo_pciecfg_resp_wr_en <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pciecfg_access.sv
// Scoreboard bench for pciecfg_access: request FIFO and PCIe core models,
// expected responses derived from delay/timeout rules at issue time.
module tb_pciecfg_access;
    import pciecfg_pkg::*;

    localparam int unsigned TO = 255;
    localparam int NEVER = 100000;

    logic                pcie_clk = 1'b0;
    logic                pcie_rst;
    logic                fifo_empty;
    logic                fifo_rd_en;
    fifo_pciecfg_t       fifo_dout;
    logic [9:0]          dwaddr;
    logic [31:0]         di;
    logic [3:0]          byte_en;
    logic                rd_en;
    logic                wr_en;
    logic                wr_readonly;
    logic                done;
    logic [31:0]         core_do;
    logic                resp_wr_en;
    fifo_pciecfg_resp_t  resp_din;
    logic                resp_full;
    logic [15:0]         stat_cnt;

    always #5 pcie_clk = ~pcie_clk;

    pciecfg_access #(.TIMEOUT_CYCLES(TO)) dut (
        .pcie_clk                (pcie_clk),
        .pcie_rst                (pcie_rst),
        .fifo_pciecfg_o_empty    (fifo_empty),
        .fifo_pciecfg_o_rd_en    (fifo_rd_en),
        .fifo_pciecfg_o_dout     (fifo_dout),
        .cfg_mgmt_dwaddr         (dwaddr),
        .cfg_mgmt_di             (di),
        .cfg_mgmt_byte_en        (byte_en),
        .cfg_mgmt_rd_en          (rd_en),
        .cfg_mgmt_wr_en          (wr_en),
        .cfg_mgmt_wr_readonly    (wr_readonly),
        .cfg_mgmt_rd_wr_done     (done),
        .cfg_mgmt_do             (core_do),
        .fifo_pciecfg_resp_wr_en (resp_wr_en),
        .fifo_pciecfg_resp_din   (resp_din),
        .fifo_pciecfg_resp_full  (resp_full),
        .stat_timeout_cnt        (stat_cnt)
    );

    typedef struct {
        fifo_pciecfg_t r;
        logic [31:0]   rdata;
        int            delay;
    } plan_t;

    typedef struct {
        fifo_pciecfg_resp_t resp;
        bit                 chk_lat;
    } exp_t;

    fifo_pciecfg_t req_q[$];
    plan_t         plan_q[$];
    exp_t          exp_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int exp_timeouts = 0;
    bit busy = 1'b0;
    bit abort_flag = 1'b0;

    always @(posedge pcie_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Queue a request; the expected response follows from the delay alone
    task automatic issue(input logic w, input logic [7:0] tag, input logic [9:0] addr,
                         input logic [3:0] be, input logic [31:0] data,
                         input logic [31:0] rdata, input int delay,
                         input bit chk_lat, input bit want_resp);
        fifo_pciecfg_t r;
        plan_t p;
        exp_t e;
        bit ok;
        r.is_write = w; r.tag = tag; r.dwaddr = addr; r.byte_en = be; r.data = data;
        p.r = r; p.rdata = rdata; p.delay = delay;
        req_q.push_back(r);
        plan_q.push_back(p);
        if (want_resp) begin
            ok = (delay < int'(TO));
            e.resp.is_write = w;
            e.resp.tag      = tag;
            e.resp.status   = ok ? STATUS_OK : STATUS_TIMEOUT;
            e.resp.data     = (ok && !w) ? rdata : 32'h0;
            e.chk_lat       = chk_lat;
            exp_q.push_back(e);
            if (!ok) exp_timeouts++;
        end
    endtask

    // Request FIFO model: data appears the cycle after the pop strobe
    initial begin
        logic [63:0] rnd;
        fifo_pciecfg_t e;
        fifo_empty = 1'b1;
        fifo_dout = '0;
        forever begin
            @(negedge pcie_clk);
            if (fifo_rd_en) begin
                check("pop_nonempty", 64'(req_q.size() != 0), 64'd1);
                if (req_q.size() != 0) begin
                    e = req_q.pop_front();
                    fifo_empty = (req_q.size() == 0);
                    @(posedge pcie_clk); #1;
                    fifo_dout = e;
                    @(posedge pcie_clk); #1;
                    rnd = {$urandom(), $urandom()};
                    fifo_dout = rnd[$bits(fifo_pciecfg_t)-1:0];
                end
            end else begin
                fifo_empty = (req_q.size() == 0);
            end
        end
    end

    // PCIe core model: answers each strobe after its planned delay
    initial begin
        plan_t p;
        int k;
        int exp_held;
        done = 1'b0;
        core_do = '0;
        k = 0;
        p.delay = NEVER; p.rdata = '0; p.r = '0;
        forever begin
            @(posedge pcie_clk); #1;
            done = 1'b0;
            core_do = $urandom();
            if (!busy && (rd_en || wr_en)) begin
                check("plan_avail", 64'(plan_q.size() != 0), 64'd1);
                if (plan_q.size() != 0) p = plan_q.pop_front();
                else p.delay = NEVER;
                busy = 1'b1;
                k = 0;
                check("strobe_kind", 64'({rd_en, wr_en}), p.r.is_write ? 64'd1 : 64'd2);
                check("dwaddr", 64'(dwaddr), 64'(p.r.dwaddr));
                if (p.r.is_write) begin
                    check("wdata", 64'(di), 64'(p.r.data));
                    check("byte_en", 64'(byte_en), 64'(p.r.byte_en));
                end
            end
            if (busy) begin
                if (rd_en || wr_en) begin
                    check("one_strobe", 64'(rd_en & wr_en), 64'd0);
                    if (k == p.delay) begin
                        done = 1'b1;
                        core_do = p.rdata;
                    end
                    k++;
                end else begin
                    busy = 1'b0;
                    exp_held = (p.delay < int'(TO)) ? p.delay + 1 : int'(TO);
                    if (!abort_flag) check("strobe_cycles", 64'(k), 64'(exp_held));
                end
            end else if ($urandom_range(7) == 0) begin
                done = 1'b1;
            end
        end
    end

    // Response monitor: pops the scoreboard on every push
    initial begin
        exp_t e;
        bit prev_full;
        int last_pop;
        prev_full = 1'b0;
        last_pop = 0;
        forever begin
            @(negedge pcie_clk);
            if (fifo_rd_en) last_pop = cyc;
            if (resp_wr_en) begin
                check("push_while_full", 64'(prev_full), 64'd0);
                check("resp_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("resp", 64'(resp_din), 64'(e.resp));
                    if (e.chk_lat) check("latency", 64'(cyc - last_pop), 64'd3);
                end
            end
            prev_full = resp_full;
        end
    end

    task automatic drain(input int limit, input bit rand_full);
        int n = 0;
        while ((req_q.size() != 0 || exp_q.size() != 0 || busy) && n < limit) begin
            @(posedge pcie_clk); #1;
            if (rand_full) resp_full = ($urandom_range(3) == 0);
            n++;
        end
        resp_full = 1'b0;
        if (n >= limit) check("drain_timeout", 64'd1, 64'd0);
        repeat (3) @(posedge pcie_clk);
        #1;
    endtask

    task automatic wait_strobe();
        int n = 0;
        while (!(rd_en || wr_en) && n < 50) begin
            @(posedge pcie_clk); #1;
            n++;
        end
        if (n >= 50) check("strobe_wait_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        exp_t snap;
        int d;
        int r;
        pcie_rst = 1'b1;
        resp_full = 1'b0;
        repeat (3) @(posedge pcie_clk);
        #1;
        check("rst_fifo_rd_en", 64'(fifo_rd_en), 64'd0);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_resp_wr_en", 64'(resp_wr_en), 64'd0);
        check("rst_dwaddr", 64'(dwaddr), 64'd0);
        check("rst_di", 64'(di), 64'd0);
        check("rst_byte_en", 64'(byte_en), 64'd0);
        check("rst_resp_din", 64'(resp_din), 64'd0);
        check("rst_stat", 64'(stat_cnt), 64'd0);
        check("wr_readonly", 64'(wr_readonly), 64'd0);
        pcie_rst = 1'b0;

        // Directed read, done on second ACCESS cycle
        issue(1'b0, 8'h11, 10'h004, 4'h0, 32'h0, 32'h0010_0547, 1, 1'b0, 1'b1);
        drain(200, 1'b0);

        // Directed write, done on first ACCESS cycle, latency checked
        issue(1'b1, 8'h22, 10'h001, 4'hF, 32'h0000_0006, 32'hDEAD_BEEF, 0, 1'b1, 1'b1);
        drain(200, 1'b0);
        check("stat_after_ok", 64'(stat_cnt), 64'd0);

        // Reset mid-ACCESS discards the request
        abort_flag = 1'b1;
        issue(1'b0, 8'h33, 10'h010, 4'h0, 32'h0, 32'h0, NEVER, 1'b0, 1'b0);
        wait_strobe();
        repeat (3) @(posedge pcie_clk);
        #1;
        pcie_rst = 1'b1;
        @(posedge pcie_clk); #1;
        check("rst_mid_rd_en", 64'(rd_en), 64'd0);
        check("rst_mid_wr_en", 64'(wr_en), 64'd0);
        pcie_rst = 1'b0;
        exp_timeouts = 0;
        repeat (5) begin
            @(posedge pcie_clk); #1;
            check("no_resp_after_rst", 64'(resp_wr_en), 64'd0);
        end
        abort_flag = 1'b0;
        issue(1'b0, 8'h44, 10'h020, 4'h0, 32'h0, 32'hCAFE_0044, 0, 1'b1, 1'b1);
        drain(200, 1'b0);

        // Timeout: done never comes
        issue(1'b0, 8'h55, 10'h030, 4'h0, 32'h0, 32'h1234_5678, NEVER, 1'b0, 1'b1);
        drain(600, 1'b0);
        check("stat_after_timeout", 64'(stat_cnt), 64'd1);

        // Backpressure held 10 cycles at RESP with a second request waiting
        issue(1'b0, 8'h66, 10'h040, 4'h0, 32'h0, 32'hA5A5_0066, 0, 1'b0, 1'b1);
        snap = exp_q[exp_q.size()-1];
        issue(1'b1, 8'h67, 10'h041, 4'h3, 32'h0000_BEEF, 32'h0, 2, 1'b0, 1'b1);
        wait_strobe();
        resp_full = 1'b1;
        @(posedge pcie_clk); #1;
        repeat (10) begin
            @(posedge pcie_clk); #1;
            check("bp_no_push", 64'(resp_wr_en), 64'd0);
            check("bp_no_pop", 64'(fifo_rd_en), 64'd0);
            check("bp_din_stable", 64'(resp_din), 64'(snap.resp));
        end
        resp_full = 1'b0;
        drain(200, 1'b0);

        // Back-to-back: four queued requests
        for (int i = 0; i < 4; i++) begin
            issue(1'(i % 2), 8'(8'h70 + i), 10'($urandom()), 4'($urandom()),
                  $urandom(), $urandom(), i, 1'b0, 1'b1);
        end
        drain(400, 1'b0);

        // Randomized traffic with backpressure and delay boundaries
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(19));
            if (r < 16)       d = int'($urandom_range(6));
            else if (r == 16) d = int'(TO) - 2;
            else if (r == 17) d = int'(TO) - 1;
            else if (r == 18) d = int'(TO);
            else              d = NEVER;
            issue(1'($urandom()), 8'($urandom()), 10'($urandom()), 4'($urandom()),
                  $urandom(), $urandom(), d, 1'b0, 1'b1);
            if ((i % 3) == 2) drain(2000, 1'b1);
        end
        drain(2000, 1'b1);
        check("stat_final", 64'(stat_cnt), 64'(exp_timeouts));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pciecfg_access.md
PCIECFG_ACCESS -- requirements
Module: pciecfg_access

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the maximum number of cycles to wait for cfg_mgmt_rd_wr_done before aborting an access.
REQ-002 pcie_clk  in  1  sole clock; all logic is on its rising edge.
REQ-003 pcie_rst  in  1  reset, synchronous, active-high.
REQ-004 fifo_pciecfg_o_empty  in  1  request FIFO (FWFT off, 1-cycle read latency) empty.
REQ-005 fifo_pciecfg_o_rd_en  out  1  request FIFO pop.
REQ-006 fifo_pciecfg_o_dout  in  FIFO_PCIECFG_T  request entry {is_write 1, tag 8, dwaddr 10, byte_en 4, data 32}.
REQ-007 cfg_mgmt_dwaddr  out  10  config-space DW address.
REQ-008 cfg_mgmt_di  out  32  write data.
REQ-009 cfg_mgmt_byte_en  out  4  write byte enables.
REQ-010 cfg_mgmt_rd_en / cfg_mgmt_wr_en  out  1 each  access strobes, held until done or timeout.
REQ-011 cfg_mgmt_wr_readonly  out  1  tied 0.
REQ-012 cfg_mgmt_rd_wr_done  in  1  access-complete pulse from the PCIe core.
REQ-013 cfg_mgmt_do  in  32  read data, valid with rd_wr_done.
REQ-014 fifo_pciecfg_resp_wr_en  out  1  response FIFO push.
REQ-015 fifo_pciecfg_resp_din  out  FIFO_PCIECFG_RESP_T  {is_write 1, tag 8, status 2, data 32}.
REQ-016 fifo_pciecfg_resp_full  in  1  response FIFO full.
REQ-017 stat_timeout_cnt  out  16  count of timed-out accesses.

Function
REQ-018 FSM states: IDLE, FETCH, ACCESS, RESP.
REQ-019 IDLE: if !empty and !resp_full, then assert rd_en for exactly one cycle and go to FETCH; otherwise stay in IDLE.
REQ-020 FETCH (the 1-cycle read latency): latch dout into a request register and go to ACCESS.
REQ-021 ACCESS: drive dwaddr, di and byte_en from the latched request; assert rd_en or wr_en according to is_write, exactly one of the two, continuously until exit.
REQ-022 ACCESS exit: on rd_wr_done, capture do (read) or 0 (write) and set status 2'b00 (OK); otherwise, once the wait counter reaches TIMEOUT_CYCLES, set data 0, status 2'b01 (TIMEOUT) and increment stat_timeout_cnt; either way go to RESP.
REQ-023 Wait counter: 8 bits wide, cleared on ACCESS entry, increments once per ACCESS cycle, saturates, never wraps.
REQ-024 If rd_wr_done and timeout occur in the same cycle, done wins: status OK, counter not incremented.
REQ-025 RESP: if !resp_full, assert resp_wr_en for one cycle with {is_write, tag, status, data} and go to IDLE; otherwise hold in RESP with resp_wr_en low and the data stable.
REQ-026 Only one outstanding access at a time; rd_en never asserts outside IDLE.
REQ-027 A rd_wr_done arriving outside ACCESS is ignored.
REQ-028 stat_timeout_cnt saturates at 16'hFFFF.
REQ-029 Latency with done on the first ACCESS cycle and no backpressure: pop to resp_wr_en is 3 cycles.
REQ-030 Byte enables are passed to the PCIe core unchanged on writes and ignored on reads.

Reset
REQ-031 On pcie_rst: state is IDLE, and fifo_pciecfg_o_rd_en, cfg_mgmt_rd_en, cfg_mgmt_wr_en and fifo_pciecfg_resp_wr_en are all 0.
REQ-032 On pcie_rst: cfg_mgmt_dwaddr, cfg_mgmt_di, cfg_mgmt_byte_en, resp din, the wait counter and stat_timeout_cnt are all 0.
REQ-033 Reset asserted mid-ACCESS or mid-RESP drops the strobes the next cycle and discards the in-flight request without issuing a response.

Structure
REQ-034 FIFO_PCIECFG_T, FIFO_PCIECFG_RESP_T, the status encodings (OK=0, TIMEOUT=1) and the state enum are defined in pciecfg_pkg.
REQ-035 Single flat module; no sub-module is needed.

Verification
REQ-036 Read: dwaddr=10'h004, tag=8'h11; core returns done on the 2nd ACCESS cycle with do=32'h0010_0547 -> one response {0, 8'h11, OK, 32'h0010_0547}.
REQ-037 Write: dwaddr=10'h001, data=32'h0000_0006, be=4'hF; done on the 1st ACCESS cycle -> wr_en high 1 cycle with di=32'h6, response {1, tag, OK, 0}, latency 3 cycles.
REQ-038 Timeout: read with done never asserted -> rd_en held 255 cycles, response status TIMEOUT with data 0, stat_timeout_cnt=1.
REQ-039 Backpressure: resp_full held 10 cycles at RESP -> din stable and no push until full drops, then exactly one push, and no new pop beforehand.
REQ-040 Back-to-back: 4 queued requests -> 4 responses in order with matching tags, and never more than one strobe asserted at a time.
REQ-041 Reset mid-ACCESS -> strobes low the next cycle, no response emitted, and the next queued request processed normally.
